// File: rtl/bcd_seq_conv_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Optional feature macro: BCD_SIGNED_IN_EN (two's-complement input).
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned DATA_W  = 20;
    localparam int unsigned DIGITS  = 6;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned SHIFT_W = DATA_W + 4 * DIGITS;
    localparam logic [DATA_W-1:0] BCD_MAX = 20'd999_999;

endpackage

// File: rtl/bcd_seq_conv_if.sv
// Request/result bundle between the converter and its user (display stage).
interface bcd_seq_conv_if;
    import bcd_pkg::*;

    logic [DATA_W-1:0] data;
    logic              start;
    logic              busy;
    logic              done;
    logic [3:0]        unit;
    logic [3:0]        ten;
    logic [3:0]        hun;
    logic [3:0]        tho;
    logic [3:0]        t_tho;
    logic [3:0]        h_hun;
    logic              sign;
    logic              ovf;

    modport master (
        output data, start,
        input  busy, done, unit, ten, hun, tho, t_tho, h_hun, sign, ovf
    );

    modport slave (
        input  data, start,
        output busy, done, unit, ten, hun, tho, t_tho, h_hun, sign, ovf
    );

endinterface

// File: rtl/bcd_seq_conv_add3.sv
// Per-digit double-dabble correction: nibbles of 5 or more get +3.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Correct before the shift so the digit carries into the next nibble.
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bcd_seq_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3), 21-cycle latency.
// Optional feature macro: BCD_SIGNED_IN_EN (two's-complement input, sign flag).
module bcd_seq_conv
    import bcd_pkg::*;
(
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    bcd_seq_conv_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_t               state_q;
    state_t               state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [SHIFT_W-1:0]   sr_q;
    logic [SHIFT_W-1:0]   sr_adj;
    logic [DATA_W-1:0]    mag;
    logic                 accept;
    logic                 ovf_pend_q;
    logic [4*DIGITS-1:0]  digits_q;
    logic                 done_q;
    logic                 ovf_q;

    assign accept = (state_q == IDLE) && bus.start;

`ifdef BCD_SIGNED_IN_EN
    logic sign_pend_q;
    logic sign_q;

    // Magnitude of a two's-complement input; -524288 maps to 524288.
    always_comb begin
        mag = bus.data;
        if (bus.data[DATA_W-1]) begin
            mag = -bus.data;
        end
    end

    // Sign is captured at acceptance and only published with the result.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sign_pend_q <= 1'b0;
            sign_q      <= 1'b0;
        end else begin
            if (accept) begin
                sign_pend_q <= bus.data[DATA_W-1];
            end
            if (state_q == DONE) begin
                sign_q <= sign_pend_q;
            end
        end
    end

    assign bus.sign = sign_q;
`else
    assign mag      = bus.data;
    assign bus.sign = 1'b0;
`endif

    // One add-3 stage per BCD digit; the binary part passes through.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3 u_add3 (
            .din  (sr_q  [DATA_W + 4*g +: 4]),
            .dout (sr_adj[DATA_W + 4*g +: 4])
        );
    end
    assign sr_adj[DATA_W-1:0] = sr_q[DATA_W-1:0];

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start is only honoured in IDLE, never queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SHIFT;
            SHIFT:   if (cnt_q == CNT_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: load on accept, shift during SHIFT, publish on DONE.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sr_q       <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            digits_q   <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            done_q <= (state_q == DONE);
            if (accept) begin
                sr_q       <= {{(SHIFT_W-DATA_W){1'b0}}, mag};
                cnt_q      <= '0;
                ovf_pend_q <= (mag > BCD_MAX);
            end else if (state_q == SHIFT) begin
                sr_q  <= SHIFT_W'({sr_adj, 1'b0});
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == DONE) begin
                digits_q <= ovf_pend_q ? {DIGITS{4'd9}} : sr_q[SHIFT_W-1 -: 4*DIGITS];
                ovf_q    <= ovf_pend_q;
            end
        end
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = done_q;
    assign bus.ovf   = ovf_q;
    assign bus.h_hun = digits_q[23:20];
    assign bus.t_tho = digits_q[19:16];
    assign bus.tho   = digits_q[15:12];
    assign bus.hun   = digits_q[11:8];
    assign bus.ten   = digits_q[7:4];
    assign bus.unit  = digits_q[3:0];

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Directed self-checking bench for bcd_seq_conv (both BCD_SIGNED_IN_EN builds).
module tb_bcd_seq_conv;

    logic sys_clk;
    logic sys_rst_n;
    int   n_cmp;
    int   n_err;
    int   k;
    int   bc;
    int   done_seen;

    bcd_seq_conv_if bus ();

    bcd_seq_conv dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    function automatic logic [23:0] digits();
        return {bus.h_hun, bus.t_tho, bus.tho, bus.hun, bus.ten, bus.unit};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance on falling edges until done is seen (bounded); count busy-high samples.
    task automatic wait_done(input int k0, output int k_done, output int busy_cnt);
        k_done   = k0;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && k_done < 60) begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(negedge sys_clk);
            k_done++;
        end
    endtask

    task automatic convert(input string tag, input logic [19:0] d,
                           input logic [23:0] exp_dig, input logic exp_ovf,
                           input logic exp_sign);
        int kd;
        int bcnt;
        @(negedge sys_clk);
        bus.data  = d;
        bus.start = 1'b1;
        @(negedge sys_clk);
        bus.start = 1'b0;
        chk({tag, "_busy_rise"}, 32'(bus.busy), 32'd1);
        wait_done(1, kd, bcnt);
        chk({tag, "_latency"}, 32'(kd), 32'd22);
        chk({tag, "_busy_cycles"}, 32'(bcnt), 32'd21);
        chk({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
        chk({tag, "_digits"}, 32'(digits()), 32'(exp_dig));
        chk({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
        chk({tag, "_sign"}, 32'(bus.sign), 32'(exp_sign));
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        sys_rst_n = 1'b0;
        bus.data  = '0;
        bus.start = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_digits", 32'(digits()), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_sign", 32'(bus.sign), 32'd0);
        sys_rst_n = 1'b1;

        convert("c123456", 20'd123_456, 24'h123456, 1'b0, 1'b0);
        convert("c0", 20'd0, 24'h000000, 1'b0, 1'b0);
`ifndef BCD_SIGNED_IN_EN
        convert("c999999", 20'd999_999, 24'h999999, 1'b0, 1'b0);
        convert("cmax", 20'd1_048_575, 24'h999999, 1'b1, 1'b0);
        convert("c42", 20'd42, 24'h000042, 1'b0, 1'b0);
`else
        convert("sm1", 20'hFFFFF, 24'h000001, 1'b0, 1'b1);
        convert("smin", 20'h80000, 24'h524288, 1'b0, 1'b1);
        convert("s0", 20'd0, 24'h000000, 1'b0, 1'b0);
        convert("smax", 20'd524_287, 24'h524287, 1'b0, 1'b0);
`endif

        // Starts during busy are ignored and data is not re-sampled.
        @(negedge sys_clk);
        bus.data  = 20'd7;
        bus.start = 1'b1;
        @(negedge sys_clk);
        bus.start = 1'b0;
        repeat (4) @(negedge sys_clk);
        bus.data  = 20'd500;
        bus.start = 1'b1;
        @(negedge sys_clk);
        bus.start = 1'b0;
        repeat (9) @(negedge sys_clk);
        bus.start = 1'b1;
        @(negedge sys_clk);
        bus.start = 1'b0;
        wait_done(16, k, bc);
        chk("ign_latency", 32'(k), 32'd22);
        chk("ign_digits", 32'(digits()), 32'h000007);
        // Start coinciding with done is accepted.
        bus.start = 1'b1;
        @(negedge sys_clk);
        bus.start = 1'b0;
        chk("b2b_busy", 32'(bus.busy), 32'd1);
        wait_done(1, k, bc);
        chk("b2b_latency", 32'(k), 32'd22);
        chk("b2b_digits", 32'(digits()), 32'h000500);

        // Reset mid-conversion aborts without a done pulse.
        @(negedge sys_clk);
        bus.data  = 20'd123;
        bus.start = 1'b1;
        @(negedge sys_clk);
        bus.start = 1'b0;
        repeat (9) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_digits", 32'(digits()), 32'd0);
        chk("abort_ovf", 32'(bus.ovf), 32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge sys_clk);
            if (bus.done === 1'b1) done_seen++;
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);
        chk("abort_idle", 32'(bus.busy), 32'd0);
`ifndef BCD_SIGNED_IN_EN
        convert("c654321", 20'd654_321, 24'h654321, 1'b0, 1'b0);
`else
        convert("s54321", 20'd54_321, 24'h054321, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
